// File: rtl/fp_pkg.sv
// Shared single-precision constants, feeder FSM state type and zero test.
package fp_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    typedef enum logic [1:0] {
        StIdle,
        StSendA,
        StSendB
    } feeder_state_e;

    // Sign bit ignored: both +0 and -0 count as zero.
    function automatic logic is_fp_zero(input logic [FP_W-1:0] x);
        return (x[FP_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO holding {a,b} operand pairs, with registered occupancy.
module feeder_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [PTR_W:0]    level_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/divider_operand_feeder.sv
// Buffers operand pairs and issues them to the divider's a-then-b strobe/ack handshake.
// Optional zero-divisor statistics are enabled by defining DIV_FEEDER_ZERO_DIV_FLAG_EN.
module divider_operand_feeder
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] div_a,
    output logic            div_a_stb,
    input  logic            div_a_ack,
    output logic [FP_W-1:0] div_b,
    output logic            div_b_stb,
    input  logic            div_b_ack,
    output logic [PTR_W:0]  level,
    output logic            busy
`ifdef DIV_FEEDER_ZERO_DIV_FLAG_EN
    ,
    output logic [15:0]     zero_div_cnt,
    output logic [0:0]      zero_div_seen
`endif
);

    feeder_state_e     state_q;
    logic [FP_W-1:0]   div_a_q, div_b_q;
    logic              a_stb_q, b_stb_q;
    logic [PTR_W:0]    fifo_level;
    logic [2*FP_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic              push, pop, b_done;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign b_done   = b_stb_q && div_b_ack;
    // No empty-bypass: the FSM only ever sees pairs already counted in the registered level.
    assign pop      = !fifo_empty && ((state_q == StIdle) || (state_q == StSendB && b_done));

    feeder_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .DATA_W(2 * FP_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .wr_data_i({in_a, in_b}),
        .pop_i    (pop),
        .rd_data_o(fifo_head),
        .level_o  (fifo_level),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            div_a_q <= '0;
            div_b_q <= '0;
            a_stb_q <= 1'b0;
            b_stb_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        div_a_q <= fifo_head[2*FP_W-1:FP_W];
                        div_b_q <= fifo_head[FP_W-1:0];
                        a_stb_q <= 1'b1;
                        state_q <= StSendA;
                    end
                end
                StSendA: begin
                    if (a_stb_q && div_a_ack) begin
                        a_stb_q <= 1'b0;
                        b_stb_q <= 1'b1;
                        state_q <= StSendB;
                    end
                end
                StSendB: begin
                    if (b_done) begin
                        b_stb_q <= 1'b0;
                        if (!fifo_empty) begin
                            div_a_q <= fifo_head[2*FP_W-1:FP_W];
                            div_b_q <= fifo_head[FP_W-1:0];
                            a_stb_q <= 1'b1;
                            state_q <= StSendA;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    a_stb_q <= 1'b0;
                    b_stb_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef DIV_FEEDER_ZERO_DIV_FLAG_EN
    logic [15:0] zero_cnt_q;
    logic        zero_seen_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_cnt_q  <= '0;
            zero_seen_q <= 1'b0;
        end else if (b_done && is_fp_zero(div_b_q)) begin
            zero_seen_q <= 1'b1;
            if (zero_cnt_q != 16'hFFFF) begin
                zero_cnt_q <= zero_cnt_q + 16'd1;
            end
        end
    end

    assign zero_div_cnt  = zero_cnt_q;
    assign zero_div_seen = zero_seen_q;
`endif

    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign div_a_stb = a_stb_q;
    assign div_b_stb = b_stb_q;
    assign level     = fifo_level;
    assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule
